// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC plus a 2-entry {pc, instr} prefetch buffer feeding the decoder.
// Optional build macro FETCH_STATS_EN adds the stat_fetch_cnt / stat_stall_cnt counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        misalign_err
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetch_cnt,
    output logic [31:0] stat_stall_cnt
`endif
);

    logic [31:0] fpc_q, fpc_d;
    logic [1:0]  count_q, count_d;
    logic        rdPtr_q, rdPtr_d;
    logic        wrPtr_q, wrPtr_d;
    logic        misalign_q, misalign_d;
    logic [31:0] pcBuf_q    [2];
    logic [31:0] instrBuf_q [2];
    logic        push;
    logic        pop;

    // A redirect squashes both the handshake and the fetch of the stale path.
    always_comb begin
        pop  = (count_q != 2'd0) && out_ready && !redirect_valid;
        push = !redirect_valid && ((count_q != 2'd2) || pop);
    end

    always_comb begin
        fpc_d      = fpc_q;
        count_d    = count_q;
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        misalign_d = misalign_q;
        if (redirect_valid) begin
            fpc_d   = {redirect_pc[31:2], 2'b00};
            count_d = 2'd0;
            rdPtr_d = 1'b0;
            wrPtr_d = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else begin
            if (push) begin
                fpc_d   = fpc_q + 32'd4;
                wrPtr_d = ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_d = ~rdPtr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc_q      <= RESET_PC;
            count_q    <= 2'd0;
            rdPtr_q    <= 1'b0;
            wrPtr_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            fpc_q      <= fpc_d;
            count_q    <= count_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            misalign_q <= misalign_d;
        end
    end

    // Payload storage needs no reset; count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            pcBuf_q[wrPtr_q]    <= fpc_q;
            instrBuf_q[wrPtr_q] <= im_instr;
        end
    end

    always_comb begin
        im_addr      = fpc_q;
        out_valid    = (count_q != 2'd0);
        out_instr    = out_valid ? instrBuf_q[rdPtr_q] : NOP_INSTR;
        out_pc       = out_valid ? pcBuf_q[rdPtr_q] : fpc_q;
        out_pc_plus4 = out_pc + 32'd4;
        misalign_err = misalign_q;
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetchCnt_q;
    logic [31:0] stallCnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetchCnt_q <= 32'd0;
            stallCnt_q <= 32'd0;
        end else begin
            if (push) begin
                fetchCnt_q <= fetchCnt_q + 32'd1;
            end
            if (out_valid && !out_ready) begin
                stallCnt_q <= stallCnt_q + 32'd1;
            end
        end
    end

    assign stat_fetch_cnt = fetchCnt_q;
    assign stat_stall_cnt = stallCnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, the value driven on out_instr when out_valid=0.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port im_addr  output  32  byte address presented to the instruction memory.
REQ-006 SHALL have port im_instr  input  32  instruction returned combinationally by the instruction memory for im_addr.
REQ-007 SHALL have port redirect_valid  input  1  taken branch/jump; redirects fetch.
REQ-008 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-009 SHALL have port out_valid  output  1  head entry is valid for the decoder.
REQ-010 SHALL have port out_ready  input  1  decoder accepts head entry this cycle.
REQ-011 SHALL have port out_instr  output  32  head instruction.
REQ-012 SHALL have port out_pc  output  32  head instruction address.
REQ-013 SHALL have port out_pc_plus4  output  32  out_pc+4, modulo 2^32.
REQ-014 SHALL have port misalign_err  output  1  sticky flag for a redirect to a non-word-aligned target.

Function
REQ-015 SHALL hold a fetch PC register (fpc) and drive im_addr = fpc combinationally.
REQ-016 SHALL buffer fetched {pc, instr} pairs in a 2-entry FIFO with registered count (0..2), read pointer and write pointer.
REQ-017 SHALL pop the head when out_valid=1 and out_ready=1 (pop); out_valid SHALL equal (count!=0).
REQ-018 SHALL push {fpc, im_instr} and advance fpc by 4 when count<2, or when count=2 and pop occurs in the same cycle (push).
REQ-019 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-020 SHALL not push when count=2 and no pop; fpc SHALL hold (stall).
REQ-021 SHALL wrap fpc from 32'hFFFF_FFFC to 32'h0000_0000 without any flag.
REQ-022 SHALL give redirect_valid priority over push and pop: count<=0, pointers<=0, fpc<={redirect_pc[31:2],2'b00}, no push, no pop that cycle.
REQ-023 SHALL set misalign_err<=1 when redirect_valid=1 and redirect_pc[1:0]!=0; it clears only on reset.
REQ-024 SHALL present a pushed instruction on out_instr no earlier than the next cycle (1-cycle fetch-to-decode latency).
REQ-025 SHALL drive out_instr=NOP_INSTR, out_pc=fpc and out_pc_plus4=fpc+4 while out_valid=0.
REQ-026 SHALL keep out_instr/out_pc stable while out_valid=1 and out_ready=0 (no redirect).

Reset
REQ-027 SHALL, on a clk edge with rst_n=0: fpc<=RESET_PC, count<=0, pointers<=0, misalign_err<=0; hence out_valid=0, im_addr=RESET_PC.
REQ-028 SHALL, on reset mid-operation, discard all buffered entries regardless of out_ready or redirect_valid.
REQ-029 SHALL fetch RESET_PC in the first cycle with rst_n=1 and assert out_valid with out_pc=RESET_PC in the next cycle.

Configuration
REQ-030 SHALL, when macro FETCH_STATS_EN is defined, add outputs stat_fetch_cnt (32) counting pushes and stat_stall_cnt (32) counting cycles with out_valid=1, out_ready=0; both reset to 0, wrap modulo 2^32, unaffected by redirect.
REQ-031 SHALL, when FETCH_STATS_EN is undefined, omit both ports and counters with no other behavioural change.

Verification
REQ-032 SHALL cover sequential fetch: RESET_PC=0, IM words 0x00200093, 0x00300113, 0x001101B3, out_ready=1 -> out_pc 0,4,8 on consecutive cycles from cycle 1, matching instructions.
REQ-033 SHALL cover backpressure: out_ready=0 for 5 cycles -> count saturates at 2, fpc holds at 8, out_pc stays 0; out_ready=1 -> out_pc 0,4,8 with no gap or loss.
REQ-034 SHALL cover redirect with full FIFO: count=2, redirect_valid=1, redirect_pc=0x100, out_ready=1 -> next cycle out_valid=0, im_addr=0x100; following cycle out_pc=0x100.
REQ-035 SHALL cover misaligned redirect: redirect_pc=0x102 -> im_addr=0x100, misalign_err=1, remains 1 after further redirects until rst_n=0.
REQ-036 SHALL cover wrap and reset mid-op: RESET_PC=32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; rst_n=0 while count=2 -> out_valid=0 next cycle, im_addr=RESET_PC.
REQ-037 SHALL cover FETCH_STATS_EN: 3 pushes and 2 stall cycles -> stat_fetch_cnt=3, stat_stall_cnt=2.
